// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus bundle for apb_master.
// master: the requester's view; slave: the view of whatever drives commands and answers the bus.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output pselx, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  pselx, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP->ACCESS transfer, answered on a response port.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         pclk,
    input  logic         preset,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
`endif

    // Single-process FSM; every bus and handshake output is a register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.pselx     <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.pwrite    <= bus.cmd_write;
                        bus.paddr     <= bus.cmd_addr;
                        bus.pwdata    <= bus.cmd_wdata;
                        bus.cmd_ready <= 1'b0;
                        bus.pselx     <= 1'b1;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ACCESS: begin
                    // pready wins over a timeout that expires in the same cycle
                    if (bus.pready) begin
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                        bus.pselx     <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.pselx     <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: directed transfers against a small APB memory model.
// Expected responses are queued at command issue and popped by an independent response monitor.
module tb_apb_master;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic pclk;
    logic preset;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;
    rsp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // APB memory slave with programmable wait states, error and hang
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int acc_cnt   = 0;
    int slv_waits = 0;
    bit slv_err   = 1'b0;
    bit slv_hang  = 1'b0;

    assign bus.pready  = bus.pselx && bus.penable && !slv_hang && (acc_cnt >= slv_waits);
    assign bus.pslverr = bus.pready && slv_err;
    assign bus.prdata  = mem[bus.paddr];

    always @(posedge pclk) begin
        if (bus.pselx && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (bus.pselx && bus.penable && bus.pready && bus.pwrite && !slv_err)
            mem[bus.paddr] <= bus.pwdata;
    end

    // Response monitor
    always @(negedge pclk) begin : mon
        rsp_t e;
        if (!preset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got rdata 0x%08h err %0d with no response outstanding",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check1("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    task automatic set_rsp_ready(input logic v);
        @(posedge pclk);
        #1 bus.rsp_ready = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check1("cmd_ready_timeout", bus.cmd_ready, 1'b1);
    endtask

    // Issue one command (at a negedge) and follow it to RESP or until the cycle budget runs out
    task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit push, input logic [DW-1:0] exp_rdata, input bit exp_err,
                        input int exp_lat);
        int lat = 1;
        int bad = 0;
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        if (push) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~a;
        bus.cmd_wdata = ~d;
        check1("setup_pselx", bus.pselx, 1'b1);
        check1("setup_penable", bus.penable, 1'b0);
        check1("setup_cmd_ready", bus.cmd_ready, 1'b0);
        check("setup_paddr", 32'(bus.paddr), 32'(a));
        check("setup_pwdata", bus.pwdata, d);
        check1("setup_pwrite", bus.pwrite, w);
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge pclk);
            lat++;
            if (!bus.rsp_valid && !(bus.pselx && bus.penable && bus.paddr == a &&
                                    bus.pwdata == d && bus.pwrite == w)) bad++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("access_unstable_cycles", 32'(bad), 32'd0);
        check("resp_bus_released", 32'({bus.pselx, bus.penable}), 32'd0);
    endtask

    task automatic reset_pulse();
        preset = 1'b1;
        @(negedge pclk);
        check1("rst_pselx", bus.pselx, 1'b0);
        check1("rst_penable", bus.penable, 1'b0);
        check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        preset = 1'b0;
    endtask

    initial begin
        int bad;
        int held;
        logic [DW-1:0] hold_rdata;
        logic hold_err;
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge pclk);

        check1("reset_cmd_ready", bus.cmd_ready, 1'b1);
        check1("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check1("reset_pselx", bus.pselx, 1'b0);
        check1("reset_penable", bus.penable, 1'b0);
        check1("reset_pwrite", bus.pwrite, 1'b0);
        check1("reset_rsp_err", bus.rsp_err, 1'b0);
        check("reset_paddr", 32'(bus.paddr), 32'd0);
        check("reset_pwdata", bus.pwdata, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        preset = 1'b0;
        @(negedge pclk);

        // Write then read back, zero wait states
        xfer(1'b1, 10'h005, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 3);
        xfer(1'b0, 10'h005, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);

        // Three wait states at the top address; with a limit of 4 this is still normal completion
        slv_waits = 3;
        xfer(1'b1, 10'h3FF, 32'h000000A5, 1'b1, 32'h0, 1'b0, 6);
        xfer(1'b0, 10'h3FF, 32'h0, 1'b1, 32'h000000A5, 1'b0, 6);
        slv_waits = 0;

        // Backpressure: response held 5 cycles, a command pulse in that window is dropped
        set_rsp_ready(1'b0);
        @(negedge pclk);
        xfer(1'b0, 10'h3FF, 32'h0, 1'b1, 32'h000000A5, 1'b0, 3);
        hold_rdata = bus.rsp_rdata;
        hold_err   = bus.rsp_err;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_rdata != hold_rdata ||
                bus.rsp_err != hold_err || bus.pselx) bad++;
            if (i == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 10'h00A;
                bus.cmd_wdata = 32'h12345678;
            end
            if (i == 2) bus.cmd_valid = 1'b0;
            if (i < 4) @(negedge pclk);
        end
        check("backpressure_unstable_cycles", 32'(bad), 32'd0);
        check("backpressure_rdata", hold_rdata, 32'h000000A5);
        set_rsp_ready(1'b1);
        bad = 0;
        repeat (5) begin
            @(negedge pclk);
            if (bus.pselx || bus.paddr != 10'h3FF) bad++;
        end
        check("dropped_cmd_bus_activity", 32'(bad), 32'd0);
        check1("dropped_cmd_cmd_ready", bus.cmd_ready, 1'b1);

        // Slave error, then a clean transfer
        slv_err = 1'b1;
        xfer(1'b0, 10'h005, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 3);
        xfer(1'b1, 10'h006, 32'h00000055, 1'b1, 32'h0, 1'b1, 3);
        slv_err = 1'b0;
        xfer(1'b0, 10'h005, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);

        // Reset during ACCESS: transfer dropped, no response
        slv_hang = 1'b1;
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h005;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        check1("pre_reset_penable", bus.penable, 1'b1);
        reset_pulse();
        slv_hang = 1'b0;
        repeat (10) @(negedge pclk);
        check("reset_drop_queue", 32'(exp_q.size()), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout after 4 ACCESS cycles with pready tied low
        slv_hang = 1'b1;
        xfer(1'b0, 10'h005, 32'h0, 1'b1, 32'h0, 1'b1, 6);
        slv_hang = 1'b0;
`else
        // No timeout: bus stays in ACCESS until reset
        slv_hang = 1'b1;
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h005;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        held = 0;
        repeat (100) begin
            @(negedge pclk);
            if (bus.pselx && bus.penable && !bus.rsp_valid) held++;
        end
        check("hang_access_cycles", 32'(held), 32'd100);
        reset_pulse();
        slv_hang = 1'b0;
`endif
        xfer(1'b0, 10'h005, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);

        repeat (3) @(negedge pclk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
